// File: rtl/ps2_arrow_decoder_pkg.sv
// Shared constants, state encodings and the arrow-code lookup for the PS/2 arrow decoder.
package ps2_pkg;

  // Scan code set 2 bytes of interest
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  // Bit positions inside the key vector (ARROW_UP = 4'b0001)
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORM    = 2'd0,
    DEC_BRK     = 2'd1,
    DEC_EXT     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  // One-hot key mask for an arrow make/break code; zero for any other byte
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_arrow_decoder_rx.sv
// PS/2 byte receiver: pin synchroniser, clock glitch filter, 11-bit frame FSM and inactivity timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_filt_level;
  logic [FW-1:0] r_filt_cnt;
  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_scan_code;
  logic          r_scan_valid;
  logic          r_frame_err;

  logic w_clk_s;
  logic w_data_s;
  logic w_filt_flip;
  logic w_strobe;
  logic w_timeout;
  logic w_frame_good;
  logic w_frame_bad;

  assign w_clk_s  = r_clk_sync[1];
  assign w_data_s = r_data_sync[1];

  // The filtered level flips on the FILTER_LEN-th consecutive sample that disagrees with it
  assign w_filt_flip = (w_clk_s != r_filt_level) && (r_filt_cnt == FILT_LAST);
  assign w_strobe    = w_filt_flip && r_filt_level;
  assign w_timeout   = (r_state != RX_IDLE) && !w_strobe && (r_to_cnt == TO_LAST);

  // Two-stage synchronisers; reset to the idle-high bus level so no false edge appears
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Glitch filter on the synchronised PS/2 clock
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_filt_level <= 1'b1;
      r_filt_cnt   <= '0;
    end else if (w_clk_s == r_filt_level) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_filt_level <= w_clk_s;
      r_filt_cnt   <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Frame FSM next state and end-of-frame verdict
  always_comb begin
    w_state_next = r_state;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    if (w_timeout) begin
      w_state_next = RX_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE:   if (!w_data_s) w_state_next = RX_DATA;
        RX_DATA:   if (r_bit_cnt == 3'd7) w_state_next = RX_PARITY;
        RX_PARITY: w_state_next = RX_STOP;
        RX_STOP: begin
          w_state_next = RX_IDLE;
          // Odd parity over data+parity and a high stop bit make a good frame
          if (w_data_s && (^{r_shift, r_parity})) w_frame_good = 1'b1;
          else                                    w_frame_bad  = 1'b1;
        end
        default:   w_state_next = RX_IDLE;
      endcase
    end
  end

  // Frame FSM state register
  always_ff @(posedge pclk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_next;
  end

  // Shift register, bit counter, timeout counter and output pulses
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= w_frame_good;
      r_frame_err  <= w_frame_bad | w_timeout;
      if (w_frame_good) r_scan_code <= r_shift;
      if (r_state == RX_IDLE || w_strobe) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + 1'b1;
      if (w_strobe) begin
        case (r_state)
          RX_IDLE:   r_bit_cnt <= '0;
          RX_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          RX_PARITY: r_parity <= w_data_s;
          default:   r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  assign scan_code  = r_scan_code;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: receives scan codes and keeps a held up/down/left/right vector.
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] w_scan_code;
  logic       w_scan_valid;
  logic       w_frame_err;
  logic [3:0] w_mask;
  dec_state_t r_dec;
  dec_state_t w_dec_next;
  logic [3:0] r_key;
  logic [3:0] w_key_next;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (w_scan_code),
    .scan_valid(w_scan_valid),
    .frame_err (w_frame_err)
  );

  assign w_mask = arrow_mask(w_scan_code);

  // Prefix tracking (E0 / F0) and key set/clear, advanced only by receiver events
  always_comb begin
    w_dec_next = r_dec;
    w_key_next = r_key;
    if (w_frame_err) begin
      w_dec_next = DEC_NORM;
    end else if (w_scan_valid) begin
      case (r_dec)
        DEC_NORM: begin
          if (w_scan_code == SC_EXT)      w_dec_next = DEC_EXT;
          else if (w_scan_code == SC_BRK) w_dec_next = DEC_BRK;
          else if (w_scan_code == SC_OVR0 || w_scan_code == SC_OVR1) w_key_next = 4'b0000;
        end
        DEC_BRK: w_dec_next = DEC_NORM;
        DEC_EXT: begin
          if (w_scan_code == SC_BRK) begin
            w_dec_next = DEC_EXT_BRK;
          end else begin
            w_dec_next = DEC_NORM;
            w_key_next = r_key | w_mask;
          end
        end
        DEC_EXT_BRK: begin
          w_dec_next = DEC_NORM;
          w_key_next = r_key & ~w_mask;
        end
        default: w_dec_next = DEC_NORM;
      endcase
    end
  end

  // Decoder state and held key vector
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_dec <= DEC_NORM;
      r_key <= 4'b0000;
    end else begin
      r_dec <= w_dec_next;
      r_key <= w_key_next;
    end
  end

  assign key        = r_key;
  assign scan_code  = w_scan_code;
  assign scan_valid = w_scan_valid;
  assign frame_err  = w_frame_err;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Randomised and directed bench for ps2_arrow_decoder against an event-level model.
module tb_ps2_arrow_decoder;

  localparam int HALF    = 30;
  localparam int TIMEOUT = 1500;
  localparam int EV_ERR  = 256;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [3:0] m_key = 4'b0000;
  int m_state = 0;   // 0 plain, 1 after F0, 2 after E0, 3 after E0 F0
  bit chk_en = 1'b0;

  logic [7:0] tbl [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00, 8'hFF, 8'h1C, 8'h12};
  logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  ps2_arrow_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] arrow_bit(input logic [7:0] b);
    if (b == 8'h75) return 4'b0001;
    if (b == 8'h72) return 4'b0010;
    if (b == 8'h6B) return 4'b0100;
    if (b == 8'h74) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_state == 0) begin
      if (b == 8'hE0) m_state = 2;
      else if (b == 8'hF0) m_state = 1;
      else if (b == 8'h00 || b == 8'hFF) m_key = 4'b0000;
    end else if (m_state == 1) begin
      m_state = 0;
    end else if (m_state == 2) begin
      if (b == 8'hF0) m_state = 3;
      else begin m_key = m_key | arrow_bit(b); m_state = 0; end
    end else begin
      m_key = m_key & ~arrow_bit(b);
      m_state = 0;
    end
  endfunction

  // Every cycle: key must track the model; each receiver event must match the queue head
  always @(negedge pclk) begin
    if (chk_en) begin
      check("key", int'(key), int'(m_key));
      if (rst) begin
        m_key = 4'b0000;
        m_state = 0;
      end else if (scan_valid || frame_err) begin
        int act;
        int e;
        act = scan_valid ? int'(scan_code) : EV_ERR;
        if (exp_q.size() == 0) begin
          check("unexpected_event", act, -1);
        end else begin
          e = exp_q.pop_front();
          check("event", act, e);
          if (e == EV_ERR) m_state = 0;
          else model_byte(e[7:0]);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    exp_q.push_back((bad_par || bad_stop) ? EV_ERR : int'(b));
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_drain(200);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    wait_cycles(3);
  endtask

  task automatic lit_key(input string name, input logic [3:0] exp);
    @(negedge pclk);
    check(name, int'(key), int'(exp));
    #1;
  endtask

  initial begin
    wait_cycles(4);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge pclk);
    check("rst_scan_code", int'(scan_code), 0);
    check("rst_scan_valid", int'(scan_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_key", int'(key), 0);
    #1;

    // Press up
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("up_press", 4'b0001);
    check("last_scan_code", int'(scan_code), 8'h75);

    // Right with up held, then release up
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    lit_key("up_right", 4'b1001);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("up_release", 4'b1000);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h74, 0, 0);
    lit_key("right_release", 4'b0000);

    // Bad parity on the code byte, then a clean press
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 1, 0);
    lit_key("bad_parity", 4'b0000);
    check("bad_parity_scan_code", int'(scan_code), 8'hE0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("after_bad", 4'b0001);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("clear_up", 4'b0000);

    // Bad stop bit
    send_frame(8'h1C, 0, 1);
    lit_key("bad_stop", 4'b0000);

    // Partial frame abandoned: timeout
    exp_q.push_back(EV_ERR);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_drain(TIMEOUT + 300);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    lit_key("after_timeout", 4'b0100);

    // One-cycle glitch on ps2_clk must produce nothing
    ps2_clk = 1'b0;
    wait_cycles(1);
    ps2_clk = 1'b1;
    wait_cycles(60);
    lit_key("glitch", 4'b0100);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("plain_break", 4'b0100);
    send_frame(8'h1C, 0, 0);
    lit_key("other_byte", 4'b0100);
    send_frame(8'hFF, 0, 0);
    lit_key("overrun", 4'b0000);

    // Reset mid-frame with up+down held
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h72, 0, 0);
    lit_key("up_down", 4'b0011);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    lit_key("mid_reset", 4'b0000);
    wait_cycles(20);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    lit_key("post_reset", 4'b0001);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        send_frame(8'hE0, 0, 0);
        send_frame(arrows[$urandom_range(0, 3)], 0, 0);
      end else if (kind == 1) begin
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(arrows[$urandom_range(0, 3)], 0, 0);
      end else if (kind == 2) begin
        send_frame(tbl[$urandom_range(0, 9)], 0, 0);
      end else begin
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end
    end
    wait_cycles(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
